// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: a PC-indexed table of 2-bit saturating
// counters. It gives a registered prediction, trains on resolved outcomes,
// pulses on mispredictions and keeps branch/mispredict statistics.
module branch_predictor #(
   parameter int IDX_BITS = 4,
   parameter int CNT_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_valid,
   input  logic                fetch_stall,
   input  logic [31:0]         fetch_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   input  logic                update_valid,
   input  logic [31:0]         update_pc,
   input  logic                update_taken,
   input  logic                update_pred,
   output logic                mispredict,
   output logic [CNT_BITS-1:0] branch_count,
   output logic [CNT_BITS-1:0] mispredict_count
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam logic [1:0] CNT_INIT = 2'b01;  // weak not-taken

   typedef struct packed {
      logic                vld;
      logic [IDX_BITS-1:0] idx;
      logic                taken;
      logic                pred;
   } upd_req_t;

   logic [1:0]          tbl [ENTRIES];
   logic [IDX_BITS-1:0] f_idx;
   upd_req_t            upd;
   logic [1:0]          upd_cur;
   logic [1:0]          upd_nxt;
   logic                mis_hit;
   logic                unused_pc_bits;

   // Untagged index: word-aligned low PC bits; aliasing PCs share a counter.
   assign f_idx = fetch_pc[IDX_BITS+1:2];
   assign upd   = {update_valid, update_pc[IDX_BITS+1:2], update_taken, update_pred};

   // PC bits outside the index field do not take part in prediction.
   assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                             update_pc[31:IDX_BITS+2], update_pc[1:0]};

   // Saturating step of the counter addressed by the update port.
   always_comb begin
      upd_cur = tbl[upd.idx];
      upd_nxt = upd_cur;
      if (upd.taken) begin
         if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
      end else begin
         if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
      end
   end

   assign mis_hit = upd.vld & (upd.taken ^ upd.pred);

   // Counter table: trained on every reported branch, never stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= CNT_INIT;
      end else if (upd.vld) begin
         tbl[upd.idx] <= upd_nxt;
      end
   end

   // Prediction register; reads the table before this edge's update (read-old).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
      end else if (!fetch_stall) begin
         pred_valid <= fetch_valid;
         pred_taken <= fetch_valid & tbl[f_idx][1];
      end
   end

   // Mispredict pulse and statistics; both land in the cycle after the update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict       <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         mispredict <= mis_hit;
         if (upd.vld) branch_count     <= branch_count + 1'b1;
         if (mis_hit) mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver applies directed and random
// stimulus and pushes the expected response from a behavioural model; a
// monitor pops and compares after every clock edge.
module tb_branch_predictor;

   localparam int IDX_BITS = 4;
   localparam int CNT_BITS = 32;
   localparam int ENTRIES  = 1 << IDX_BITS;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                fetch_valid = 1'b0;
   logic                fetch_stall = 1'b0;
   logic [31:0]         fetch_pc = '0;
   logic                pred_valid;
   logic                pred_taken;
   logic                update_valid = 1'b0;
   logic [31:0]         update_pc = '0;
   logic                update_taken = 1'b0;
   logic                update_pred = 1'b0;
   logic                mispredict;
   logic [CNT_BITS-1:0] branch_count;
   logic [CNT_BITS-1:0] mispredict_count;

   branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_stall(fetch_stall), .fetch_pc(fetch_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_taken(update_taken), .update_pred(update_pred),
      .mispredict(mispredict), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit pv;
      bit pt;
      bit mis;
      longint bc;
      longint mc;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: counter strength as an integer 0..3 per table slot.
   int     m_ctr [ENTRIES];
   bit     m_pv, m_pt;
   longint m_bc, m_mc;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
      m_pv = 0; m_pt = 0; m_bc = 0; m_mc = 0;
   endtask

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; expectation for the following edge goes to the queue.
   task automatic step(input bit fv, input bit st, input logic [31:0] fpc,
                       input bit uv, input logic [31:0] upc, input bit ut, input bit up);
      exp_t e;
      bit   mis;
      @(negedge clk);
      fetch_valid = fv; fetch_stall = st; fetch_pc = fpc;
      update_valid = uv; update_pc = upc; update_taken = ut; update_pred = up;
      if (!st) begin
         m_pv = fv;
         m_pt = fv && (m_ctr[slot(fpc)] >= 2);
      end
      if (uv) begin
         if (ut) m_ctr[slot(upc)] = (m_ctr[slot(upc)] == 3) ? 3 : m_ctr[slot(upc)] + 1;
         else    m_ctr[slot(upc)] = (m_ctr[slot(upc)] == 0) ? 0 : m_ctr[slot(upc)] - 1;
      end
      mis = uv && (ut != up);
      if (uv)  m_bc = (m_bc + 1) % (64'd1 << CNT_BITS);
      if (mis) m_mc = (m_mc + 1) % (64'd1 << CNT_BITS);
      e.pv = m_pv; e.pt = m_pt; e.mis = mis; e.bc = m_bc; e.mc = m_mc;
      exp_q.push_back(e);
   endtask

   task automatic look(input logic [31:0] pc);
      step(1, 0, pc, 0, 0, 0, 0);
   endtask

   task automatic upd(input logic [31:0] pc, input bit t, input bit p);
      step(0, 0, 0, 1, pc, t, p);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare the DUT against the oldest pending expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pred_valid", longint'(pred_valid), longint'(e.pv));
            check("pred_taken", longint'(pred_taken), longint'(e.pt));
            check("mispredict", longint'(mispredict), longint'(e.mis));
            check("branch_count", longint'(branch_count), e.bc);
            check("mispredict_count", longint'(mispredict_count), e.mc);
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("queue_drained", longint'(exp_q.size()), 0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state: first lookup predicts not-taken, counts are zero.
      look(32'h100);

      // Training to taken with mispredictions, saturation, hysteresis.
      upd(32'h100, 1, 0);
      upd(32'h100, 1, 0);
      look(32'h100);
      repeat (3) upd(32'h100, 1, 1);
      look(32'h100);
      upd(32'h100, 0, 1);
      look(32'h100);
      upd(32'h100, 0, 1);
      look(32'h100);

      // Aliasing: 0x044 shares 0x004's slot, 0x008 does not.
      upd(32'h004, 1, 0);
      upd(32'h004, 1, 1);
      look(32'h044);
      look(32'h008);

      // Same-edge lookup and update: read-old, then the new value.
      step(1, 0, 32'h200, 1, 32'h200, 1, 0);
      look(32'h200);

      // Stall holds a taken prediction while the stalled PC is not-taken;
      // the update during the stall still trains 0x300.
      look(32'h004);
      step(1, 1, 32'h008, 1, 32'h300, 1, 0);
      step(1, 1, 32'h008, 0, 0, 0, 0);
      step(1, 1, 32'h008, 0, 0, 0, 0);
      look(32'h300);
      look(32'h004);
      drain();

      // Asynchronous reset between edges clears outputs without a clock.
      @(posedge clk);
      #3;
      check("pre_reset_pred_taken", longint'(pred_taken), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_pred_valid", longint'(pred_valid), 0);
      check("async_rst_pred_taken", longint'(pred_taken), 0);
      check("async_rst_mispredict", longint'(mispredict), 0);
      check("async_rst_branch_count", longint'(branch_count), 0);
      check("async_rst_mispredict_count", longint'(mispredict_count), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      look(32'h004);  // history discarded: weak not-taken again

      // Random traffic over a few aliasing PCs.
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] fpc, upc;
         fpc = {22'd0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63))};
         upc = {22'd0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63))};
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), fpc,
              ($urandom_range(0, 2) != 0), upc,
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1));
      end
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the fetch stage, built on a table of 2-bit saturating counters indexed by PC.
- Issues a registered taken/not-taken prediction for each fetched branch.
- The execute stage reports the actual outcome (the resolved branch condition) back through the update port.
- The block trains its counter, flags mispredictions for the redirect/flush logic, and keeps branch and misprediction statistics.

Parameters:
- IDX_BITS, 4, log2 of table entries (16 entries by default); legal range 1..10.
- CNT_BITS, 32, width of the statistics counters.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- fetch_valid  input  1  a branch lookup is requested this cycle.
- fetch_stall  input  1  hold the prediction outputs; has priority over fetch_valid.
- fetch_pc  input  32  PC of the instruction being looked up.
- pred_valid  output  1  prediction outputs are meaningful.
- pred_taken  output  1  predicted direction (1 = taken).
- update_valid  input  1  a resolved branch is being reported.
- update_pc  input  32  PC of the resolved branch.
- update_taken  input  1  actual outcome from branch resolution.
- update_pred  input  1  prediction that was used for this branch, carried down the pipeline.
- mispredict  output  1  one-cycle pulse: the last reported branch was mispredicted.
- branch_count  output  CNT_BITS  number of updates accepted.
- mispredict_count  output  CNT_BITS  number of mispredictions.

Behaviour:
- Index: idx = pc[IDX_BITS+1:2]; pc[1:0] and the upper bits are ignored. There is no tag, so aliasing PCs share a counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff bit 1 is set.
- Reset (rst_n low, asynchronous):
  - all counters = 01;
  - pred_valid = 0, pred_taken = 0, mispredict = 0;
  - both statistics counters = 0.
  - Reset asserted mid-operation discards all history immediately.
- Lookup, 1-cycle latency:
  - On an edge with fetch_stall = 0: pred_valid <= fetch_valid; pred_taken <= fetch_valid ? table[idx(fetch_pc)][1] : 0.
  - On an edge with fetch_stall = 1: pred_valid and pred_taken hold their values, regardless of fetch_valid.
- Update:
  - On an edge with update_valid = 1: table[idx(update_pc)] saturating-increments if update_taken, otherwise saturating-decrements. 11 stays 11 on taken; 00 stays 00 on not-taken.
  - Updates are never stalled or dropped, including while fetch_stall = 1.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update counter value (read-old). The update still takes effect.
- Mispredict:
  - mispredict <= update_valid & (update_taken ^ update_pred) on every edge, so it is high for exactly one cycle per mispredicted update.
  - The block uses update_pred as given and does not re-derive it from the table.
- Statistics:
  - branch_count += 1 on each update_valid edge.
  - mispredict_count += 1 on each edge where the mispredict condition holds.
  - Both wrap modulo 2^CNT_BITS.
  - Both are registered: the new value is visible the cycle after the update, in the same cycle as the mispredict pulse.
- No combinational path from any input to any output.

Test Plan:
- Reset behaviour: pulse rst_n low, then look up pc=0x100 -> pred_valid=1, pred_taken=0 one cycle later; both counts = 0.
- Training to taken: 2 updates pc=0x100 taken, update_pred=0 -> counter 01->10->11; lookup gives pred_taken=1; mispredict pulses twice; mispredict_count=2, branch_count=2.
- Saturation and hysteresis:
  - 3 further taken updates -> counter stays 11.
  - 1 not-taken update -> counter 10, prediction still taken.
  - 2nd not-taken update -> counter 01, pred_taken=0.
- Aliasing: with IDX_BITS=4, train pc=0x004 to 11, then look up pc=0x044 -> pred_taken=1. Look up pc=0x008 -> pred_taken=0.
- Same-cycle read/update: counter at 01, lookup and taken update of pc=0x200 on the same edge -> pred_taken=0. Next lookup -> pred_taken=1.
- Stall and asynchronous reset:
  - pred_taken=1 held while fetch_stall=1 across 3 lookups of a not-taken PC.
  - An update during the stall still changes its counter.
  - rst_n dropped between edges -> outputs go to 0 immediately, without a clock edge.
